// File: rtl/led_sched_pkg.sv
// Shared definitions for the LED sequencer: widths, register map, mode encodings.
// LED_REG_WIDTH may be overridden on the command line before this file is read.
`ifndef LED_REG_WIDTH
`define LED_REG_WIDTH 10
`endif

package led_sched_pkg;
    localparam int LED_W      = `LED_REG_WIDTH;
    localparam int PRESCALE_W = 24;
    localparam logic [PRESCALE_W-1:0] DEF_PRESCALE = 24'd2_500_000;

    localparam logic [1:0] LED_ADDR_VAL      = 2'd0;
    localparam logic [1:0] LED_ADDR_MASK     = 2'd1;
    localparam logic [1:0] LED_ADDR_MODE     = 2'd2;
    localparam logic [1:0] LED_ADDR_PRESCALE = 2'd3;

    typedef enum logic [1:0] {
        LED_MODE_STATIC = 2'd0,
        LED_MODE_BLINK  = 2'd1,
        LED_MODE_CHASE  = 2'd2
    } led_mode_e;

    // Encoding 3 is storable but sequences as STATIC.
    function automatic led_mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return LED_MODE_BLINK;
            2'd2:    return LED_MODE_CHASE;
            default: return LED_MODE_STATIC;
        endcase
    endfunction
endpackage

// File: rtl/led_sched_if.sv
// CPU-side register bus of the LED sequencer: single-cycle write strobe, combinational read.
interface led_sched_if;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output we, addr, wdata, input rdata);
    modport slave  (input we, addr, wdata, output rdata);
endinterface

// File: rtl/led_sched_tick_gen.sv
// Prescale down-counter: pulses tick when the count hits zero, then reloads prescale.
// A reload request loads reload_val and suppresses that cycle's tick.
module led_sched_tick_gen #(
    parameter int             W       = 24,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         reload,
    input  logic [W-1:0] reload_val,
    input  logic [W-1:0] prescale,
    output logic         tick
);
    logic [W-1:0] cnt;

    assign tick = (cnt == '0) && !reload;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           cnt <= RST_VAL;
        else if (reload)      cnt <= reload_val;
        else if (cnt == '0)   cnt <= prescale;
        else                  cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/led_sched.sv
// Register-mapped LED sequencer producing the registered led_reg vector.
// Optional macro LED_SCHED_PWM_EN adds a 4-bit duty gate taken from MODE[7:4].
//
// state           | meaning
// LED_MODE_STATIC | led_reg follows LED_VAL
// LED_MODE_BLINK  | masked bits drop out while phase is 0, phase toggles per tick
// LED_MODE_CHASE  | rotating one-hot ORed onto LED_VAL, advances per tick
module led_sched
    import led_sched_pkg::*;
#(
    parameter int                      LED_W        = led_sched_pkg::LED_W,
    parameter int                      PRESCALE_W   = led_sched_pkg::PRESCALE_W,
    parameter logic [PRESCALE_W-1:0]   DEF_PRESCALE = led_sched_pkg::DEF_PRESCALE
) (
    input  logic             clk,
    input  logic             rst_n,
    led_sched_if.slave       bus,
    output logic [LED_W-1:0] led_reg
);
`ifdef LED_SCHED_PWM_EN
    localparam logic [7:0] MODE_RST  = 8'hF0;
    localparam logic [7:0] MODE_KEEP = 8'hFF;
`else
    localparam logic [7:0] MODE_RST  = 8'h00;
    localparam logic [7:0] MODE_KEEP = 8'h0F;
`endif

    logic [LED_W-1:0]      led_val, blink_mask;
    logic [7:0]            mode_reg;
    logic [PRESCALE_W-1:0] prescale;
    led_mode_e             cur_state, nxt_state;
    logic                  phase, nxt_phase;
    logic [LED_W-1:0]      pos, nxt_pos;
    logic [LED_W-1:0]      pattern;
    logic                  tick;
    logic                  wr_mode, wr_pre;
    logic [PRESCALE_W-1:0] reload_val;
    logic                  unused_wdata;

    assign wr_mode      = bus.we && (bus.addr == LED_ADDR_MODE);
    assign wr_pre       = bus.we && (bus.addr == LED_ADDR_PRESCALE);
    assign reload_val   = wr_pre ? bus.wdata[PRESCALE_W-1:0] : prescale;
    assign unused_wdata = ^bus.wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_val    <= '0;
            blink_mask <= '0;
            mode_reg   <= MODE_RST;
            prescale   <= DEF_PRESCALE;
        end else if (bus.we) begin
            case (bus.addr)
                LED_ADDR_VAL:  led_val    <= bus.wdata[LED_W-1:0];
                LED_ADDR_MASK: blink_mask <= bus.wdata[LED_W-1:0];
                LED_ADDR_MODE: mode_reg   <= bus.wdata[7:0] & MODE_KEEP;
                default:       prescale   <= bus.wdata[PRESCALE_W-1:0];
            endcase
        end
    end

    always_comb begin
        bus.rdata = '0;
        case (bus.addr)
            LED_ADDR_VAL:  bus.rdata = {{(32-LED_W){1'b0}}, led_val};
            LED_ADDR_MASK: bus.rdata = {{(32-LED_W){1'b0}}, blink_mask};
            LED_ADDR_MODE: bus.rdata = {24'd0, mode_reg};
            default:       bus.rdata = {{(32-PRESCALE_W){1'b0}}, prescale};
        endcase
    end

    led_sched_tick_gen #(.W(PRESCALE_W), .RST_VAL(DEF_PRESCALE)) u_tick (
        .clk        (clk),
        .rst_n      (rst_n),
        .reload     (wr_mode || wr_pre),
        .reload_val (reload_val),
        .prescale   (prescale),
        .tick       (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= LED_MODE_STATIC;
            phase     <= 1'b1;
            pos       <= LED_W'(1);
        end else begin
            cur_state <= nxt_state;
            phase     <= nxt_phase;
            pos       <= nxt_pos;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        nxt_phase = phase;
        nxt_pos   = pos;
        pattern   = led_val;
        if (wr_mode) begin
            nxt_state = decode_mode(bus.wdata[1:0]);
            nxt_phase = 1'b1;
            nxt_pos   = LED_W'(1);
        end
        case (cur_state)
            LED_MODE_BLINK: begin
                pattern = phase ? led_val : (led_val & ~blink_mask);
                if (tick) nxt_phase = ~phase;
            end
            LED_MODE_CHASE: begin
                pattern = pos | led_val;
                if (tick) nxt_pos = {pos[LED_W-2:0], pos[LED_W-1]};
            end
            default: pattern = led_val;
        endcase
    end

`ifdef LED_SCHED_PWM_EN
    logic [3:0] pwm_cnt;
    logic       pwm_on;

    assign pwm_on = (pwm_cnt <= mode_reg[7:4]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            led_reg <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            led_reg <= pattern & {LED_W{pwm_on}};
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) led_reg <= '0;
        else        led_reg <= pattern;
    end
`endif
endmodule

// File: tb/tb_led_sched.sv
// Directed self-checking bench for led_sched; expectations are hand-derived constants.
module tb_led_sched;
    import led_sched_pkg::*;

`ifdef LED_SCHED_PWM_EN
    localparam logic [31:0] MODE_HI = 32'hF0;
`else
    localparam logic [31:0] MODE_HI = 32'h00;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [LED_W-1:0] led_reg;
    int               n_tests = 0;
    int               n_fail  = 0;

    led_sched_if bus();

    led_sched dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .led_reg (led_reg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives a write so that the next rising edge is the write edge; returns 1 ns after it.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.we    = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        @(posedge clk);
        #1;
        bus.we    = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        bus.addr = a;
        #1;
        chk(tag, bus.rdata, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ones;
        rst_n     = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = 2'd0;
        bus.wdata = 32'd0;

        repeat (3) @(negedge clk);
        chk("rst_led", 32'(led_reg), 32'h0);
        rst_n = 1'b1;
        step();
        chk("rst_led_after", 32'(led_reg), 32'h0);
        rd_chk("rst_prescale", LED_ADDR_PRESCALE, 32'd2_500_000);
        rd_chk("rst_mode", LED_ADDR_MODE, MODE_HI);
        rd_chk("rst_mask", LED_ADDR_MASK, 32'h0);

        // STATIC: one cycle from write edge to led_reg
        wr(LED_ADDR_VAL, 32'hFFFF_F2A5);
        chk("static_at_write_edge", 32'(led_reg), 32'h0);
        step();
        chk("static_latency1", 32'(led_reg), 32'h2A5);
        rd_chk("val_readback", LED_ADDR_VAL, 32'h2A5);
        wr(LED_ADDR_MODE, 32'hF3);
        rd_chk("mode3_readback", LED_ADDR_MODE, MODE_HI | 32'h3);
        repeat (3) step();
        chk("mode3_static", 32'(led_reg), 32'h2A5);

        // BLINK: period 4 cycles per phase, starts in phase 1
        wr(LED_ADDR_PRESCALE, 32'hFF00_0003);
        rd_chk("prescale_readback", LED_ADDR_PRESCALE, 32'h3);
        wr(LED_ADDR_VAL, 32'h3FF);
        wr(LED_ADDR_MASK, 32'h00F);
        wr(LED_ADDR_MODE, 32'hF1);
        for (int j = 1; j <= 16; j++) begin
            step();
            chk($sformatf("blink_%0d", j), 32'(led_reg),
                (((j - 1) / 4) % 2 == 0) ? 32'h3FF : 32'h3F0);
        end

        // Collision: MODE rewrite lands exactly on a tick edge
        repeat (3) @(posedge clk);
        wr(LED_ADDR_MODE, 32'hF1);
        for (int j = 1; j <= 5; j++) begin
            step();
            chk($sformatf("collide_%0d", j), 32'(led_reg), (j <= 4) ? 32'h3FF : 32'h3F0);
        end

        // CHASE: tick every cycle, wrap from bit 9 back to bit 0
        wr(LED_ADDR_PRESCALE, 32'h0);
        wr(LED_ADDR_VAL, 32'h0);
        wr(LED_ADDR_MODE, 32'hF2);
        for (int i = 0; i <= 10; i++) begin
            step();
            chk($sformatf("chase_%0d", i), 32'(led_reg), 32'(1) << (i % LED_W));
        end
        wr(LED_ADDR_VAL, 32'h200);
        chk("chase_val_write_edge", 32'(led_reg), 32'h002);
        for (int i = 12; i <= 21; i++) begin
            step();
            chk($sformatf("chase_val_%0d", i), 32'(led_reg), (32'(1) << (i % LED_W)) | 32'h200);
        end

        // Asynchronous reset mid-chase
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_led", 32'(led_reg), 32'h0);
        rd_chk("async_rst_prescale", LED_ADDR_PRESCALE, 32'd2_500_000);
        rd_chk("async_rst_val", LED_ADDR_VAL, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Duty 3 in MODE[7:4]: gated 4/16 with PWM, constant otherwise
        wr(LED_ADDR_VAL, 32'h3FF);
        wr(LED_ADDR_MODE, 32'h30);
        repeat (2) step();
        ones = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (led_reg == 10'h3FF) ones++;
        end
`ifdef LED_SCHED_PWM_EN
        chk("pwm_on_cycles", 32'(ones), 32'd4);
        rd_chk("pwm_mode_readback", LED_ADDR_MODE, 32'h30);
`else
        chk("nopwm_on_cycles", 32'(ones), 32'd16);
        rd_chk("nopwm_mode_readback", LED_ADDR_MODE, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/led_sched.md
Name: led_sched

Overview:
- Register-mapped LED sequencer that owns and produces the board LED register vector.
- A CPU-side MMIO slave writes a static pattern, a blink mask, a mode and a tick prescale.
- The block sequences static, blink or chase patterns on an internal tick and drives the registered led_reg vector into the board LED driver.
- Sits between the memory-mapped bus decoder and the LED pin driver.

Parameters:
- LED_W, `LED_REG_WIDTH (10): number of LEDs driven.
- PRESCALE_W, 24: width of the tick prescale counter.
- DEF_PRESCALE, 24'd2_500_000: reset value of the PRESCALE register (20 Hz tick at 50 MHz).

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- we  in  1  write strobe, one cycle per write.
- addr  in  2  register select: 0 LED_VAL, 1 BLINK_MASK, 2 MODE, 3 PRESCALE.
- wdata  in  32  write data; unused upper bits ignored.
- rdata  out  32  combinational readback of the register at addr, zero-extended.
- led_reg  out  LED_W  registered LED vector to the LED driver.

Behaviour:
- Reset values: LED_VAL=0, BLINK_MASK=0, MODE=STATIC(0), PRESCALE=DEF_PRESCALE, tick counter=DEF_PRESCALE, phase=1, chase position=bit0, led_reg=0.
- Writes take effect at the clock edge where we=1. led_reg reflects the new value on the following edge (1-cycle latency from the write edge).
- Tick generator: counter decrements each cycle. When it equals 0, a 1-cycle tick pulse is emitted and the counter reloads PRESCALE. PRESCALE=0 gives a tick every cycle.
- A PRESCALE write reloads the counter with the new value in the same cycle; no tick is emitted that cycle.
- MODE[1:0] selects the state: STATIC=0, BLINK=1, CHASE=2. Value 3 is stored but behaves as STATIC.
- Mode changes occur only on a MODE write. Any MODE write, including a rewrite of the same mode, restarts that mode:
  - phase=1, chase position=bit0, tick counter reloaded with PRESCALE.
  - A tick coinciding with a MODE write is discarded.
- STATIC: led_reg = LED_VAL.
- BLINK: phase toggles on each tick. led_reg = phase ? LED_VAL : (LED_VAL & ~BLINK_MASK). Unmasked bits stay static.
- CHASE: one-hot position rotates left by 1 on each tick, wrapping from bit LED_W-1 to bit 0. led_reg = onehot | LED_VAL.
- LED_VAL or BLINK_MASK writes do not disturb phase, position or counter.
- Widths: registers store wdata[LED_W-1:0], MODE wdata[7:0] and PRESCALE wdata[PRESCALE_W-1:0]; readback zero-extends.
- Asserting rst_n low mid-sequence immediately forces all reset values, including led_reg=0.

Optional Feature:
- Macro: LED_SCHED_PWM_EN.
- Defined:
  - MODE[7:4] is a 4-bit duty d, reset value 15.
  - A free-running 4-bit PWM counter p increments every cycle.
  - The final output is gated: led_reg = pattern & {LED_W{p <= d}}, so d=15 is always on and d=0 is on 1/16 of cycles.
  - The PWM gate is also registered, keeping 1-cycle latency.
- Undefined: MODE[7:4] ignored and reads 0; no PWM counter; output is ungated.

Decomposition:
- Shared package/header led_defs holds:
  - `LED_REG_WIDTH
  - address map constants LED_ADDR_VAL/MASK/MODE/PRESCALE
  - mode encodings LED_MODE_STATIC/BLINK/CHASE
  - DEF_PRESCALE
- One natural sub-module: led_tick_gen. It holds the prescale down-counter with a reload input and a tick output, and is reusable by other timed drivers.

Test Plan:
- Reset: hold rst_n=0, then release → led_reg=0, rdata@3=2_500_000, rdata@2=0.
- STATIC: write LED_VAL=0x2A5 → led_reg=0x2A5 exactly 1 cycle after the write edge; MODE=3 also yields 0x2A5.
- BLINK: PRESCALE=3, LED_VAL=0x3FF, BLINK_MASK=0x00F, MODE=1 → led_reg alternates 0x3FF / 0x3F0 every 4 cycles, starting with 0x3FF.
- CHASE wrap: PRESCALE=0, LED_VAL=0, MODE=2 → led_reg 0x001, 0x002 … 0x200, then 0x001; LED_VAL=0x200 written mid-chase → bit 9 stays set, chase continues unbroken.
- Collision: MODE=1 rewritten on the same cycle a tick would fire → no toggle that cycle, phase=1, counter reloaded. rst_n pulsed low mid-chase → led_reg=0 asynchronously.
- PWM (macro on): STATIC 0x3FF, duty=3 → led_reg high exactly 4 of every 16 cycles. Macro off: same write → constant 0x3FF, rdata@2[7:4]=0.
